// File: rtl/dpi_pkg.sv
// Shared types and constants for the DPI stream sequencer and its seen table.
package dpi_pkg;

  localparam int unsigned STREAM_ID_W          = 6;
  localparam int unsigned CHAR_W               = 8;
  localparam int unsigned NUM_STREAMS          = 1 << STREAM_ID_W;
  localparam int unsigned DRAIN_CYCLES_DEFAULT = 2;
  // Wide enough for the legal DRAIN_CYCLES range 1..15.
  localparam int unsigned DRAIN_CNT_W          = 4;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSettle,
    StStream,
    StDrain,
    StEop,
    StResult
  } dpi_state_e;

endpackage

// File: rtl/dpi_stream_seen_table.sv
// One bit per stream ID recording whether the stream has been seen since reset or clear.
// A set and a clear in the same cycle leave the set bit high.
module dpi_stream_seen_table
  import dpi_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   set_en,
  input  logic [STREAM_ID_W-1:0] set_id,
  input  logic                   clear,
  input  logic [STREAM_ID_W-1:0] lookup_id,
  output logic                   lookup_seen
);

  logic [NUM_STREAMS-1:0] seen_q;
  logic [NUM_STREAMS-1:0] seen_d;

  // Next table: clear first, then apply the set so it wins for its ID.
  always_comb begin
    seen_d = clear ? '0 : seen_q;
    if (set_en) begin
      seen_d[set_id] = 1'b1;
    end
  end

  // Table register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seen_q <= '0;
    end else begin
      seen_q <= seen_d;
    end
  end

  assign lookup_seen = seen_q[lookup_id];

endmodule

// File: rtl/dpi_stream_sequencer.sv
// Packet-side driver for a bank of per-regex DPI matchers: header accept, state load,
// settle, char stream, drain, end-of-packet strobe and handshaked fired-mask result.
module dpi_stream_sequencer
  import dpi_pkg::*;
#(
  parameter int unsigned NUM_REGEX    = 8,
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   hdr_vld,
  output logic                   hdr_rdy,
  input  logic [STREAM_ID_W-1:0] hdr_stream_id,
  input  logic [NUM_REGEX-1:0]   hdr_enable,
  input  logic                   byte_vld,
  output logic                   byte_rdy,
  input  logic [CHAR_W-1:0]      byte_data,
  input  logic                   byte_last,
  input  logic                   clear_streams,
  output logic                   load_state,
  output logic                   new_stream_id,
  output logic [STREAM_ID_W-1:0] stream_id,
  output logic [NUM_REGEX-1:0]   enable,
  output logic [CHAR_W-1:0]      char_in,
  output logic                   char_in_vld,
  output logic                   eop,
  input  logic [NUM_REGEX-1:0]   fired_in,
  output logic                   res_vld,
  input  logic                   res_rdy,
  output logic [STREAM_ID_W-1:0] res_stream_id,
  output logic [NUM_REGEX-1:0]   res_fired,
  output logic [15:0]            pkt_count
);

  dpi_state_e             state_q;
  logic [DRAIN_CNT_W-1:0] drain_cnt_q;
  logic                   id_seen;

  dpi_stream_seen_table u_seen_table (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_en     (state_q == StEop),
    .set_id     (stream_id),
    .clear      (clear_streams),
    .lookup_id  (hdr_stream_id),
    .lookup_seen(id_seen)
  );

  assign char_in     = byte_data;
  assign char_in_vld = byte_vld & byte_rdy;

  // Packet FSM; every strobe and ready is registered alongside the state it belongs to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      drain_cnt_q   <= '0;
      hdr_rdy       <= 1'b1;
      byte_rdy      <= 1'b0;
      load_state    <= 1'b0;
      eop           <= 1'b0;
      res_vld       <= 1'b0;
      new_stream_id <= 1'b0;
      stream_id     <= '0;
      enable        <= '0;
      res_stream_id <= '0;
      res_fired     <= '0;
      pkt_count     <= '0;
    end else begin
      load_state <= 1'b0;
      eop        <= 1'b0;
      case (state_q)
        StIdle: begin
          if (hdr_vld) begin
            stream_id     <= hdr_stream_id;
            enable        <= hdr_enable;
            new_stream_id <= ~id_seen;
            hdr_rdy       <= 1'b0;
            load_state    <= 1'b1;
            state_q       <= StLoad;
          end
        end
        StLoad: begin
          state_q <= StSettle;
        end
        StSettle: begin
          byte_rdy <= 1'b1;
          state_q  <= StStream;
        end
        StStream: begin
          if (byte_vld && byte_last) begin
            byte_rdy    <= 1'b0;
            drain_cnt_q <= DRAIN_CNT_W'(DRAIN_CYCLES);
            state_q     <= StDrain;
          end
        end
        StDrain: begin
          if (drain_cnt_q <= DRAIN_CNT_W'(1)) begin
            eop     <= 1'b1;
            state_q <= StEop;
          end else begin
            drain_cnt_q <= drain_cnt_q - DRAIN_CNT_W'(1);
          end
        end
        StEop: begin
          res_fired     <= fired_in & enable;
          res_stream_id <= stream_id;
          pkt_count     <= pkt_count + 16'd1;
          res_vld       <= 1'b1;
          state_q       <= StResult;
        end
        StResult: begin
          if (res_rdy) begin
            res_vld <= 1'b0;
            hdr_rdy <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// Directed bench for dpi_stream_sequencer with a result scoreboard and a cycle monitor.
module tb_dpi_stream_sequencer;

  localparam int unsigned DRAIN = 2;

  typedef struct {
    logic [5:0] id;
    logic [7:0] fired;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hdr_vld;
  logic       hdr_rdy;
  logic [5:0] hdr_stream_id;
  logic [7:0] hdr_enable;
  logic       byte_vld;
  logic       byte_rdy;
  logic [7:0] byte_data;
  logic       byte_last;
  logic       clear_streams;
  logic       load_state;
  logic       new_stream_id;
  logic [5:0] stream_id;
  logic [7:0] enable;
  logic [7:0] char_in;
  logic       char_in_vld;
  logic       eop;
  logic [7:0] fired_in;
  logic       res_vld;
  logic       res_rdy;
  logic [5:0] res_stream_id;
  logic [7:0] res_fired;
  logic [15:0] pkt_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hdr_cyc = 0, load_cyc = 0, last_cyc = 0, eop_cyc = 0, rel_cyc = 0;
  int char_cnt = 0, load_cnt = 0, eop_cnt = 0;
  logic first_pend = 1'b0;
  logic res_vld_prev = 1'b0;
  logic [7:0] pend_fired = '0;
  logic [15:0] exp_pkts = '0;
  res_t sb[$];

  dpi_stream_sequencer #(
    .NUM_REGEX   (8),
    .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hdr_vld      (hdr_vld),
    .hdr_rdy      (hdr_rdy),
    .hdr_stream_id(hdr_stream_id),
    .hdr_enable   (hdr_enable),
    .byte_vld     (byte_vld),
    .byte_rdy     (byte_rdy),
    .byte_data    (byte_data),
    .byte_last    (byte_last),
    .clear_streams(clear_streams),
    .load_state   (load_state),
    .new_stream_id(new_stream_id),
    .stream_id    (stream_id),
    .enable       (enable),
    .char_in      (char_in),
    .char_in_vld  (char_in_vld),
    .eop          (eop),
    .fired_in     (fired_in),
    .res_vld      (res_vld),
    .res_rdy      (res_rdy),
    .res_stream_id(res_stream_id),
    .res_fired    (res_fired),
    .pkt_count    (pkt_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle monitor: samples mid-cycle, so inputs seen here are those the next edge consumes.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        chk("rdy_only_in_stream", 32'(byte_rdy & (load_state | eop | res_vld | hdr_rdy)), 32'd0);
        chk("load_eop_exclusive", 32'(load_state & eop), 32'd0);
        if (hdr_vld && hdr_rdy) hdr_cyc = cyc;
      end
      if (load_state) begin
        load_cyc   = cyc;
        load_cnt++;
        first_pend = 1'b1;
      end
      if (char_in_vld) begin
        char_cnt++;
        chk("char_in", 32'(char_in), 32'(byte_data));
        if (first_pend) begin
          chk("first_char_after_load", 32'(cyc - load_cyc), 32'd2);
          first_pend = 1'b0;
        end
        if (byte_last) last_cyc = cyc;
      end
      if (eop) begin
        eop_cnt++;
        eop_cyc = cyc;
        chk("eop_offset", 32'(cyc - last_cyc), 32'(DRAIN + 1));
      end
      if (res_vld && !res_vld_prev) chk("res_vld_after_eop", 32'(cyc - eop_cyc), 32'd1);
      res_vld_prev = res_vld;
      if (res_vld && res_rdy) begin
        rel_cyc = cyc;
        chk("sb_not_empty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          res_t e;
          e = sb.pop_front();
          chk("res_stream_id", 32'(res_stream_id), 32'(e.id));
          chk("res_fired", 32'(res_fired), 32'(e.fired));
        end
      end
    end
  end

  task automatic check_reset_vals();
    chk("rst_load_state", 32'(load_state), 32'd0);
    chk("rst_eop", 32'(eop), 32'd0);
    chk("rst_char_in_vld", 32'(char_in_vld), 32'd0);
    chk("rst_res_vld", 32'(res_vld), 32'd0);
    chk("rst_byte_rdy", 32'(byte_rdy), 32'd0);
    chk("rst_hdr_rdy", 32'(hdr_rdy), 32'd1);
    chk("rst_stream_id", 32'(stream_id), 32'd0);
    chk("rst_enable", 32'(enable), 32'd0);
    chk("rst_new_stream_id", 32'(new_stream_id), 32'd0);
    chk("rst_res_fired", 32'(res_fired), 32'd0);
    chk("rst_res_stream_id", 32'(res_stream_id), 32'd0);
    chk("rst_pkt_count", 32'(pkt_count), 32'd0);
  endtask

  // Presents a header, pushes the expected result and checks the LOAD cycle.
  task automatic start_hdr(input logic [5:0] id, input logic [7:0] en, input logic [7:0] fired,
                           input logic exp_new);
    int n = 0;
    fired_in = '0;
    while (!hdr_rdy && n < 50) begin
      tick();
      n++;
    end
    chk("hdr_rdy_wait", 32'(hdr_rdy), 32'd1);
    hdr_vld       = 1'b1;
    hdr_stream_id = id;
    hdr_enable    = en;
    sb.push_back('{id: id, fired: en & fired});
    tick();
    hdr_vld       = 1'b0;
    hdr_stream_id = 6'($urandom);
    hdr_enable    = 8'($urandom);
    chk("load_state", 32'(load_state), 32'd1);
    chk("hdr_rdy_low", 32'(hdr_rdy), 32'd0);
    chk("byte_rdy_in_load", 32'(byte_rdy), 32'd0);
    chk("new_stream_id", 32'(new_stream_id), 32'(exp_new));
    chk("stream_id", 32'(stream_id), 32'(id));
    chk("enable", 32'(enable), 32'(en));
    pend_fired = fired;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, input logic gap);
    int n = 0;
    logic acc = 1'b0;
    if (gap) begin
      byte_vld = 1'b0;
      tick();
    end
    byte_vld  = 1'b1;
    byte_data = d;
    byte_last = last;
    while (!acc && n < 50) begin
      acc = byte_rdy;
      tick();
      n++;
    end
    chk("byte_accept", 32'(acc), 32'd1);
    byte_vld  = 1'b0;
    byte_last = 1'b0;
    fired_in  = pend_fired;
  endtask

  // Waits for the result, optionally stalls it, accepts it; period check when nbytes > 0.
  task automatic finish_pkt(input int hold, input logic clr_at_eop, input int nbytes);
    int n = 0;
    int lc;
    res_rdy = (hold == 0);
    while (!res_vld && n < 60) begin
      clear_streams = clr_at_eop & eop;
      tick();
      n++;
    end
    clear_streams = 1'b0;
    chk("res_vld_wait", 32'(res_vld), 32'd1);
    if (hold > 0) begin
      lc = load_cnt;
      for (int i = 0; i < hold; i++) begin
        tick();
        chk("hold_res_vld", 32'(res_vld), 32'd1);
        chk("hold_res_fired", 32'(res_fired), 32'(sb[0].fired));
        chk("hold_hdr_rdy", 32'(hdr_rdy), 32'd0);
      end
      chk("hold_no_load", 32'(load_cnt - lc), 32'd0);
    end
    res_rdy = 1'b1;
    tick();
    exp_pkts = exp_pkts + 16'd1;
    chk("pkt_count", 32'(pkt_count), 32'(exp_pkts));
    chk("hdr_rdy_after_result", 32'(hdr_rdy), 32'd1);
    chk("res_vld_drop", 32'(res_vld), 32'd0);
    if (nbytes > 0) chk("packet_period", 32'(rel_cyc - hdr_cyc + 1), 32'(nbytes + DRAIN + 5));
  endtask

  task automatic packet(input logic [5:0] id, input logic [7:0] en, input logic [7:0] fired,
                        input logic exp_new, input int nbytes, input logic gaps, input int hold,
                        input logic clr_eop);
    int c0;
    start_hdr(id, en, fired, exp_new);
    c0 = char_cnt;
    for (int i = 0; i < nbytes; i++) send_byte(8'(8'h61 + i), i == nbytes - 1, gaps);
    finish_pkt(hold, clr_eop, (gaps || hold > 0) ? 0 : nbytes);
    chk("char_count", 32'(char_cnt - c0), 32'(nbytes));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    rst_n = 1'b0; hdr_vld = 1'b0; hdr_stream_id = '0; hdr_enable = '0;
    byte_vld = 1'b0; byte_data = '0; byte_last = 1'b0; clear_streams = 1'b0;
    fired_in = '0; res_rdy = 1'b1;
    repeat (3) tick();
    check_reset_vals();
    rst_n = 1'b1;
    tick();

    // Basic packet "ab", then seen tracking and clear.
    packet(6'd5, 8'h01, 8'h01, 1'b1, 2, 1'b0, 0, 1'b0);
    packet(6'd5, 8'h01, 8'h00, 1'b0, 1, 1'b0, 0, 1'b0);
    clear_streams = 1'b1;
    tick();
    clear_streams = 1'b0;
    packet(6'd5, 8'h01, 8'h01, 1'b1, 1, 1'b0, 0, 1'b0);
    // Enable masking, gapped payload, stalled result.
    packet(6'd9, 8'h0F, 8'hFF, 1'b1, 3, 1'b0, 0, 1'b0);
    packet(6'd9, 8'hA5, 8'h3C, 1'b0, 4, 1'b1, 0, 1'b0);
    packet(6'd63, 8'hFF, 8'h81, 1'b1, 2, 1'b0, 10, 1'b0);
    // Clear coinciding with EOP: the set for id 7 survives, others are cleared.
    packet(6'd7, 8'h02, 8'h02, 1'b1, 2, 1'b0, 0, 1'b1);
    start_hdr(6'd7, 8'h03, 8'h01, 1'b0);
    clear_streams = 1'b1;
    tick();
    clear_streams = 1'b0;
    chk("new_id_held_over_clear", 32'(new_stream_id), 32'd0);
    send_byte(8'h70, 1'b1, 1'b0);
    finish_pkt(0, 1'b0, 0);
    packet(6'd5, 8'h10, 8'hF0, 1'b1, 1, 1'b0, 0, 1'b0);

    // Reset in the middle of STREAM.
    start_hdr(6'd3, 8'hFF, 8'h00, 1'b1);
    send_byte(8'h41, 1'b0, 1'b0);
    byte_vld  = 1'b1;
    byte_data = 8'h42;
    tick();
    chk("mid_stream_byte_rdy", 32'(byte_rdy), 32'd1);
    e0       = eop_cnt;
    rst_n    = 1'b0;
    byte_vld = 1'b0;
    fired_in = '0;
    tick();
    check_reset_vals();
    rst_n = 1'b1;
    sb.delete();
    exp_pkts = '0;
    repeat (5) tick();
    chk("no_eop_after_reset", 32'(eop_cnt - e0), 32'd0);
    packet(6'd7, 8'h01, 8'h01, 1'b1, 2, 1'b0, 0, 1'b0);

    // Counter wrap.
    force dut.pkt_count = 16'hFFFF;
    tick();
    release dut.pkt_count;
    exp_pkts = 16'hFFFF;
    packet(6'd1, 8'h80, 8'h80, 1'b1, 1, 1'b0, 0, 1'b0);
    chk("pkt_count_wrapped", 32'(pkt_count), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
